// File: rtl/batch_mac_engine.sv
// Batch int8 dot-product engine: fetches 8 rows of 8 signed lanes from the data and
// weight buffers and accumulates the 64 products. Define BATCH_MAC_SAT_EN for saturation.
module batch_mac_engine (
    input  logic        i_clk,
    input  logic        i_clr,
    output logic [2:0]  o_data_row,
    input  logic [63:0] i_data,
    input  logic        i_data_ready,
    output logic [2:0]  o_weight_row,
    input  logic [63:0] i_weight,
    input  logic        i_weight_ready,
    output logic [23:0] o_acc,
    output logic        o_acc_valid,
    input  logic        i_read,
    input  logic        i_acc_clr,
    output logic        o_busy,
    output logic        o_ovf
);
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            armed_q, armed_d;
    logic            sample_vld_q, prod_vld_q;
    logic [7:0][15:0] prod_d, prod_q;
    logic [23:0]     lane_sum;
    logic [23:0]     acc_q, acc_d;
    logic            both_ready;
    logic            acc_clr_ok;

    assign both_ready = i_data_ready & i_weight_ready;
    assign acc_clr_ok = i_acc_clr && ((state_q == IDLE) || (state_q == DONE));

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            armed_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        case (state_q)
            IDLE: begin
                if (both_ready && armed_q) begin
                    state_d = FETCH;
                    cnt_d   = 3'd0;
                    armed_d = 1'b0;
                end
            end
            FETCH: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = DRAIN;
                    cnt_d   = 3'd0;
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = DONE;
                    cnt_d   = 3'd0;
                end
            end
            DONE: begin
                if (i_read) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A batch that stayed ready since the last job must not start a second one.
        if (!both_ready) begin
            armed_d = 1'b1;
        end
    end

    always_comb begin
        o_data_row   = (state_q == FETCH) ? cnt_q : 3'd0;
        o_weight_row = (state_q == FETCH) ? cnt_q : 3'd0;
        o_busy       = (state_q == FETCH) || (state_q == DRAIN);
        o_acc_valid  = (state_q == DONE);
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign prod_d[gi] = $signed({{8{i_data[8*gi+7]}}, i_data[8*gi +: 8]})
                              * $signed({{8{i_weight[8*gi+7]}}, i_weight[8*gi +: 8]});
        end
    endgenerate

    always_comb begin
        lane_sum = 24'd0;
        for (int k = 0; k < 8; k++) begin
            lane_sum = lane_sum + {{8{prod_q[k][15]}}, prod_q[k]};
        end
    end

    // Buffer rows arrive one cycle after their address, so the product stage trails FETCH by one.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            sample_vld_q <= 1'b0;
            prod_vld_q   <= 1'b0;
            prod_q       <= '0;
        end else begin
            sample_vld_q <= (state_q == FETCH);
            prod_vld_q   <= sample_vld_q;
            if (sample_vld_q) begin
                prod_q <= prod_d;
            end
        end
    end

`ifdef BATCH_MAC_SAT_EN
    logic [24:0] sum_ext;
    logic        ovf_q, ovf_d;

    assign sum_ext = {acc_q[23], acc_q} + {lane_sum[23], lane_sum};

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (prod_vld_q) begin
            if (sum_ext[24] != sum_ext[23]) begin
                acc_d = sum_ext[24] ? 24'h800000 : 24'h7FFFFF;
                ovf_d = 1'b1;
            end else begin
                acc_d = sum_ext[23:0];
            end
        end else if (acc_clr_ok) begin
            acc_d = 24'd0;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign o_ovf = ovf_q;
`else
    always_comb begin
        acc_d = acc_q;
        if (prod_vld_q) begin
            acc_d = acc_q + lane_sum;
        end else if (acc_clr_ok) begin
            acc_d = 24'd0;
        end
    end

    assign o_ovf = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            acc_q <= 24'd0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign o_acc = acc_q;
endmodule

// File: tb/tb_batch_mac_engine.sv
// Bench for batch_mac_engine: job-level reference model checked every cycle, plus
// directed jobs with hand-computed results.
module tb_batch_mac_engine;
    logic        i_clk;
    logic        i_clr;
    logic [2:0]  o_data_row;
    logic [63:0] i_data;
    logic        i_data_ready;
    logic [2:0]  o_weight_row;
    logic [63:0] i_weight;
    logic        i_weight_ready;
    logic [23:0] o_acc;
    logic        o_acc_valid;
    logic        i_read;
    logic        i_acc_clr;
    logic        o_busy;
    logic        o_ovf;

    batch_mac_engine dut (
        .i_clk          (i_clk),
        .i_clr          (i_clr),
        .o_data_row     (o_data_row),
        .i_data         (i_data),
        .i_data_ready   (i_data_ready),
        .o_weight_row   (o_weight_row),
        .i_weight       (i_weight),
        .i_weight_ready (i_weight_ready),
        .o_acc          (o_acc),
        .o_acc_valid    (o_acc_valid),
        .i_read         (i_read),
        .i_acc_clr      (i_acc_clr),
        .o_busy         (o_busy),
        .o_ovf          (o_ovf)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic [63:0] dmem [8];
    logic [63:0] wmem [8];

    // Batch buffers: one-cycle registered read on the engine clock.
    always @(posedge i_clk) begin
        i_data   <= dmem[o_data_row];
        i_weight <= wmem[o_weight_row];
    end

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 job running (offset m_off), 2 result ready.
    int m_phase = 0;
    int m_off   = 0;
    int m_acc   = 0;
    bit m_armed = 1'b1;
    bit m_ovf   = 1'b0;
    int t_ph, t_off, t_acc;
    bit t_arm, t_ovf, t_hit;

    function automatic int acc_add(input int a, input int b, output bit hit);
        int s;
        logic [23:0] t;
        s   = a + b;
        hit = 1'b0;
`ifdef BATCH_MAC_SAT_EN
        if (s > 8388607) begin
            s = 8388607;
            hit = 1'b1;
        end else if (s < -8388608) begin
            s = -8388608;
            hit = 1'b1;
        end
        return s;
`else
        t = s[23:0];
        return {{8{t[23]}}, t};
`endif
    endfunction

    function automatic int row_sum(input int r);
        int s;
        byte a, b;
        s = 0;
        for (int k = 0; k < 8; k++) begin
            a = dmem[r][8*k +: 8];
            b = wmem[r][8*k +: 8];
            s = s + int'(a) * int'(b);
        end
        return s;
    endfunction

    always @(posedge i_clk) begin
        t_ph = m_phase; t_off = m_off; t_acc = m_acc; t_arm = m_armed; t_ovf = m_ovf;
        if (i_clr) begin
            t_ph = 0; t_off = 0; t_acc = 0; t_arm = 1'b1; t_ovf = 1'b0;
        end else begin
            if (t_ph == 0) begin
                if (i_acc_clr) begin t_acc = 0; t_ovf = 1'b0; end
                if (i_data_ready && i_weight_ready && t_arm) begin
                    t_ph = 1; t_off = 0; t_arm = 1'b0;
                end
            end else if (t_ph == 1) begin
                t_off = t_off + 1;
                if (t_off == 10) begin
                    t_ph = 2;
                    for (int r = 0; r < 8; r++) begin
                        t_acc = acc_add(t_acc, row_sum(r), t_hit);
                        t_ovf = t_ovf | t_hit;
                    end
                end
            end else begin
                if (i_acc_clr) begin t_acc = 0; t_ovf = 1'b0; end
                if (i_read) t_ph = 0;
            end
            if (!i_data_ready || !i_weight_ready) t_arm = 1'b1;
        end
        m_phase <= t_ph; m_off <= t_off; m_acc <= t_acc; m_armed <= t_arm; m_ovf <= t_ovf;
    end

    always @(negedge i_clk) begin
        logic [2:0] exp_row;
        logic [23:0] exp_acc;
        if (chk_en) begin
            exp_row = (m_phase == 1 && m_off < 8) ? m_off[2:0] : 3'd0;
            exp_acc = m_acc[23:0];
            check("cyc_busy", {31'd0, o_busy}, {31'd0, m_phase == 1});
            check("cyc_valid", {31'd0, o_acc_valid}, {31'd0, m_phase == 2});
            check("cyc_drow", {29'd0, o_data_row}, {29'd0, exp_row});
            check("cyc_wrow", {29'd0, o_weight_row}, {29'd0, exp_row});
            if (m_phase != 1) begin
                check("cyc_acc", {8'd0, o_acc}, {8'd0, exp_acc});
                check("cyc_ovf", {31'd0, o_ovf}, {31'd0, m_ovf});
            end
        end
    end

    task automatic load_all(input logic [7:0] d, input logic [7:0] w);
        for (int r = 0; r < 8; r++) begin
            dmem[r] = {8{d}};
            wmem[r] = {8{w}};
        end
    endtask

    task automatic clear_acc(input string nm);
        i_acc_clr = 1'b1;
        @(negedge i_clk);
        i_acc_clr = 1'b0;
        check({nm, "_acc"}, {8'd0, o_acc}, 32'd0);
        check({nm, "_ovf"}, {31'd0, o_ovf}, 32'd0);
    endtask

    // mode 0 plain, 1 acc clear in DRAIN, 2 ready dropped mid-FETCH, 3 reset at FETCH row 4
    task automatic run_job(input string nm, input logic [23:0] exp_acc, input bit exp_ovf,
                           input int mode);
        int cyc;
        bit seen;
        i_data_ready = 1'b0;
        i_weight_ready = 1'b0;
        @(negedge i_clk);
        i_data_ready = 1'b1;
        i_weight_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge i_clk);
            if (o_busy) seen = 1'b1;
        end
        check({nm, "_start"}, {31'd0, seen}, 32'd1);
        if (!seen) return;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            i_acc_clr = (mode == 1 && cyc == 8);
            if (mode == 2 && cyc == 3) begin
                i_data_ready = 1'b0;
                i_weight_ready = 1'b0;
            end
            if (mode == 3 && cyc == 4) begin
                check({nm, "_row4"}, {29'd0, o_data_row}, 32'd4);
                i_clr = 1'b1;
                i_data_ready = 1'b0;
                i_weight_ready = 1'b0;
                @(negedge i_clk);
                i_clr = 1'b0;
                check({nm, "_busy"}, {31'd0, o_busy}, 32'd0);
                check({nm, "_acc"}, {8'd0, o_acc}, {8'd0, exp_acc});
                check({nm, "_valid"}, {31'd0, o_acc_valid}, 32'd0);
                $display("job %s aborted acc=%06h", nm, o_acc);
                return;
            end
            @(negedge i_clk);
            cyc++;
            if (o_acc_valid) seen = 1'b1;
        end
        i_acc_clr = 1'b0;
        check({nm, "_latency"}, 32'(cyc), 32'd10);
        check({nm, "_acc"}, {8'd0, o_acc}, {8'd0, exp_acc});
        check({nm, "_ovf"}, {31'd0, o_ovf}, {31'd0, exp_ovf});
        $display("job %s acc=%06h ovf=%0b latency=%0d", nm, o_acc, o_ovf, cyc);
        i_read = 1'b1;
        @(negedge i_clk);
        i_read = 1'b0;
        check({nm, "_released"}, {31'd0, o_acc_valid}, 32'd0);
        repeat (3) @(negedge i_clk);
        check({nm, "_norerun"}, {31'd0, o_busy}, 32'd0);
        check({nm, "_retained"}, {8'd0, o_acc}, {8'd0, exp_acc});
    endtask

    initial begin
        i_clr = 1'b1;
        i_data_ready = 1'b0;
        i_weight_ready = 1'b0;
        i_read = 1'b0;
        i_acc_clr = 1'b0;
        load_all(8'h00, 8'h00);
        @(negedge i_clk);
        chk_en = 1'b1;
        repeat (2) @(negedge i_clk);
        check("rst_acc", {8'd0, o_acc}, 32'd0);
        check("rst_valid", {31'd0, o_acc_valid}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_ovf", {31'd0, o_ovf}, 32'd0);
        check("rst_rows", {26'd0, o_data_row, o_weight_row}, 32'd0);
        i_clr = 1'b0;
        @(negedge i_clk);

        load_all(8'h01, 8'h01);
        run_job("ones", 24'h000040, 1'b0, 0);
        clear_acc("clr_ones");

        load_all(8'h80, 8'h80);
        run_job("neg128_a", 24'h100000, 1'b0, 0);
        run_job("neg128_b", 24'h200000, 1'b0, 0);
        clear_acc("clr_neg");

        for (int j = 0; j < 8; j++) begin
            if (j < 7) begin
                run_job("tile", 24'((j + 1) << 20), 1'b0, 0);
            end else begin
`ifdef BATCH_MAC_SAT_EN
                run_job("tile_last", 24'h7FFFFF, 1'b1, 0);
`else
                run_job("tile_last", 24'h800000, 1'b0, 0);
`endif
            end
        end
        clear_acc("clr_tile");

        load_all(8'h01, 8'h01);
        run_job("drain_clr", 24'h000040, 1'b0, 1);
        run_job("abort", 24'h000000, 1'b0, 3);

        load_all(8'h7F, 8'hFF);
        run_job("max_neg1", 24'hFFE040, 1'b0, 0);
        clear_acc("clr_max");

        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 8; k++) begin
                dmem[r][8*k +: 8] = 8'(r - 3);
                wmem[r][8*k +: 8] = 8'(k - 4);
            end
        end
        run_job("ramp", 24'hFFFFF0, 1'b0, 0);
        clear_acc("clr_ramp");

        load_all(8'h01, 8'h01);
        run_job("ready_drop", 24'h000040, 1'b0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/batch_mac_engine.md
BATCH_MAC_ENGINE -- requirements
Module: batch_mac_engine

Interface
REQ-001 SHALL have port i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port i_clr  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port o_data_row  out  3  row address to batch data buffer read conduit.
REQ-004 SHALL have port i_data  in  64  data row, 8 signed int8 lanes, lane k = bits [8k+7:8k].
REQ-005 SHALL have port i_data_ready  in  1  data buffer holds a complete 8-row batch.
REQ-006 SHALL have port o_weight_row  out  3  row address to batch weight buffer read conduit.
REQ-007 SHALL have port i_weight  in  64  weight row, same lane layout as i_data.
REQ-008 SHALL have port i_weight_ready  in  1  weight buffer holds a complete 8-row batch.
REQ-009 SHALL have port o_acc  out  24  signed accumulator, feeds serializer i_acc.
REQ-010 SHALL have port o_acc_valid  out  1  o_acc holds a finished job result.
REQ-011 SHALL have port i_read  in  1  serializer read strobe, one-cycle pulse.
REQ-012 SHALL have port i_acc_clr  in  1  serializer accumulator clear strobe, one-cycle pulse.
REQ-013 SHALL have port o_busy  out  1  job in progress (FETCH or DRAIN).
REQ-014 SHALL have port o_ovf  out  1  sticky accumulator saturation flag.
REQ-015 Buffer conduit read clocks SHALL be tied to i_clk at top level; i_data/i_weight valid exactly 1 cycle after row address presented.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, DRAIN, DONE.
REQ-017 IDLE->FETCH SHALL occur when i_data_ready=1, i_weight_ready=1 and armed=1; armed cleared on that transition.
REQ-018 armed SHALL be set in any cycle where i_data_ready=0 or i_weight_ready=0, preventing re-run on the same batch.
REQ-019 FETCH cycle n (n=0..7) SHALL drive o_data_row=o_weight_row=n; FETCH->DRAIN after n=7; rows SHALL hold 0 outside FETCH.
REQ-020 Pipeline: row n sampled end of cycle n+1; 8 lane products registered; sum of 8 products added into accumulator end of cycle n+2.
REQ-021 DRAIN SHALL last 2 cycles; DONE entered cycle 10 relative to first FETCH cycle, o_acc final and o_acc_valid=1 in that cycle.
REQ-022 Products SHALL be signed 8x8->16 bit; lane sum sign-extended to 24 bits before accumulate.
REQ-023 Accumulator SHALL NOT clear at job start; successive jobs accumulate (tiling).
REQ-024 DONE: o_acc_valid held until i_read=1, then DONE->IDLE next cycle with o_acc retained.
REQ-025 i_acc_clr in IDLE or DONE SHALL zero o_acc and o_ovf next cycle; ignored in FETCH/DRAIN.
REQ-026 i_read and i_acc_clr together in DONE SHALL clear and go IDLE.
REQ-027 i_read outside DONE SHALL be ignored.
REQ-028 Ready deassertion during FETCH/DRAIN SHALL NOT abort the job.
REQ-029 o_busy=1 exactly in FETCH and DRAIN.

Reset
REQ-030 i_clr SHALL force IDLE, armed=1, o_acc=0, o_acc_valid=0, o_busy=0, o_ovf=0, row outputs=0, pipeline registers=0, at any state including mid-job.

Configuration
REQ-031 Macro BATCH_MAC_SAT_EN defined: accumulate result SHALL saturate to +8388607 / -8388608 and set o_ovf sticky.
REQ-032 Macro BATCH_MAC_SAT_EN undefined: accumulate SHALL wrap modulo 2^24 and o_ovf SHALL be tied 0.

Verification
REQ-033 All data and weight bytes 0x01, both ready -> o_acc=64 (0x000040), o_acc_valid at cycle 10 after first FETCH.
REQ-034 All bytes 0x80 (-128) -> o_acc=1048576 (0x100000); second job after ready toggle -> 0x200000.
REQ-035 Ready held high after i_read -> no second job; drop ready 1 cycle and raise -> job restarts.
REQ-036 Eight -128x-128 jobs: SAT_EN -> o_acc=0x7FFFFF, o_ovf=1; without -> o_acc=0x800000, o_ovf=0.
REQ-037 i_clr at FETCH n=4 -> next cycle IDLE, o_acc=0; i_acc_clr during DRAIN -> ignored, result intact.
REQ-038 Data lanes 0x7F, weights 0xFF (-1) -> o_acc=-8128 (0xFFE040).
